// File: rtl/alu_pkg.sv
// Shared command codes, FSM states and command helpers
// for the digit-serial ALU.
package alu_pkg;

  localparam logic [2:0] CMD_ADD  = 3'd0;
  localparam logic [2:0] CMD_SUB  = 3'd1;
  localparam logic [2:0] CMD_XOR  = 3'd2;
  localparam logic [2:0] CMD_SLT  = 3'd3;
  localparam logic [2:0] CMD_AND  = 3'd4;
  localparam logic [2:0] CMD_NAND = 3'd5;
  localparam logic [2:0] CMD_NOR  = 3'd6;
  localparam logic [2:0] CMD_OR   = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_arith(
    input logic [2:0] cmd
  );
    return (cmd == CMD_ADD) ||
           (cmd == CMD_SUB) ||
           (cmd == CMD_SLT);
  endfunction

  function automatic logic inv_b(
    input logic [2:0] cmd
  );
    return (cmd == CMD_SUB) ||
           (cmd == CMD_SLT);
  endfunction

endpackage

// File: rtl/alu_digit.sv
// Combinational DIGIT-wide ALU slice: ripple adder
// plus bitwise logic, selected by command.
import alu_pkg::*;

module alu_digit #(
  parameter int DIGIT = 4
) (
  input  logic [2:0]       command,
  input  logic [DIGIT-1:0] a_dig,
  input  logic [DIGIT-1:0] b_dig,
  input  logic             cin,
  output logic [DIGIT-1:0] res_dig,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] bx;
  logic [DIGIT-1:0] sum;

  always_comb begin
    bx   = inv_b(command) ? ~b_dig : b_dig;
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a_dig[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a_dig[i] & bx[i]) |
                 (c[i] & (a_dig[i] ^ bx[i]));
    end
  end

  always_comb begin
    res_dig = sum;
    unique case (command)
      CMD_ADD,
      CMD_SUB,
      CMD_SLT:  res_dig = sum;
      CMD_XOR:  res_dig = a_dig ^ b_dig;
      CMD_AND:  res_dig = a_dig & b_dig;
      CMD_NAND: res_dig = ~(a_dig & b_dig);
      CMD_NOR:  res_dig = ~(a_dig | b_dig);
      CMD_OR:   res_dig = a_dig | b_dig;
    endcase
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/alu_digit_serial.sv
// Multi-cycle ALU: one DIGIT-bit chunk per clock, LSB first,
// with carry chained through a register and valid/ready I/O.
import alu_pkg::*;

module alu_digit_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       command,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [2:0]       cmd_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] fin;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] res_dig;
  logic             cout;
  logic             c_msb;
  logic             ovf;
  logic             last;
  logic             arith;

  assign a_dig = a_q[cnt*DIGIT +: DIGIT];
  assign b_dig = b_q[cnt*DIGIT +: DIGIT];

  alu_digit #(
    .DIGIT(DIGIT)
  ) u_dig (
    .command (cmd_q),
    .a_dig   (a_dig),
    .b_dig   (b_dig),
    .cin     (carry),
    .res_dig (res_dig),
    .cout    (cout),
    .c_msb   (c_msb)
  );

  assign last  = (cnt == CW'(NDIG - 1));
  assign ovf   = c_msb ^ cout;
  assign arith = is_arith(cmd_q);

  always_comb begin
    acc_nxt = acc;
    acc_nxt[cnt*DIGIT +: DIGIT] = res_dig;
  end

  // SLT collapses the finished subtraction to its sign-corrected bit
  assign fin = (cmd_q == CMD_SLT) ?
    {{(WIDTH-1){1'b0}}, acc_nxt[WIDTH-1] ^ ovf} :
    acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      carry    <= 1'b0;
      cmd_q    <= CMD_ADD;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      result   <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            cmd_q <= command;
            cnt   <= '0;
            carry <= inv_b(command);
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          acc   <= acc_nxt;
          carry <= cout;
          cnt   <= cnt + 1'b1;
          if (last) begin
            result   <= fin;
            carryout <= arith & cout;
            overflow <= arith & ovf;
            zero     <= (fin == '0);
            cnt      <= '0;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

endmodule

// File: tb/tb_alu_digit_serial.sv
// Self-checking bench for alu_digit_serial: directed, random,
// backpressure, abort and single-cycle configuration.
module tb_alu_digit_serial;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  command = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        carryout;
  logic        overflow;
  logic        zero;

  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [2:0]  command8 = 3'd0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        out_valid8;
  logic        out_ready8 = 1'b0;
  logic [7:0]  result8;
  logic        carryout8;
  logic        overflow8;
  logic        zero8;

  int n_tests = 0;
  int n_fail  = 0;

  alu_digit_serial #(.WIDTH(32), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .command(command), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carryout(carryout),
    .overflow(overflow), .zero(zero)
  );

  alu_digit_serial #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .command(command8), .a(a8), .b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .carryout(carryout8),
    .overflow(overflow8), .zero(zero8)
  );

  // Reference: {result, carryout, overflow, zero} from plain arithmetic
  function automatic logic [34:0] model(
    input logic [2:0] cmd,
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic [32:0] s;
    logic [31:0] r;
    logic co, ov;
    co = 1'b0; ov = 1'b0; r = '0; s = '0;
    case (cmd)
      3'd0: begin
        s  = {1'b0, x} + {1'b0, y};
        r  = s[31:0];
        co = s[32];
        ov = (x[31] == y[31]) && (s[31] != x[31]);
      end
      3'd1, 3'd3: begin
        s  = {1'b0, x} - {1'b0, y};
        co = !s[32];
        ov = (x[31] != y[31]) && (s[31] != x[31]);
        if (cmd == 3'd1) r = s[31:0];
        else r = {31'd0, ($signed(x) < $signed(y))};
      end
      3'd2: r = x ^ y;
      3'd4: r = x & y;
      3'd5: r = ~(x & y);
      3'd6: r = ~(x | y);
      default: r = x | y;
    endcase
    return {r, co, ov, (r == 32'd0)};
  endfunction

  task automatic run_op(
    input logic [2:0] cmd,
    input logic [31:0] x,
    input logic [31:0] y,
    output int lat
  );
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    command = cmd; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    n_tests++;
    if ({in_ready, out_valid, result, carryout, overflow, zero}
        !== {1'b1, 1'b0, 32'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset: rdy=%b vld=%b r=%h co=%b ov=%b z=%b exp rdy=1 vld=0 all 0",
               in_ready, out_valid, result, carryout, overflow, zero);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  tc [10];
    logic [31:0] ta [10];
    logic [31:0] tb [10];
    logic [34:0] te [10];
    int lat;
    tc[0] = CMD_ADD;  ta[0] = 32'h7FFFFFFF; tb[0] = 32'h1;
    te[0] = {32'h80000000, 3'b010};
    tc[1] = CMD_SUB;  ta[1] = 32'h5; tb[1] = 32'h5;
    te[1] = {32'h0, 3'b101};
    tc[2] = CMD_ADD;  ta[2] = 32'hFFFFFFFF; tb[2] = 32'h1;
    te[2] = {32'h0, 3'b101};
    tc[3] = CMD_SLT;  ta[3] = 32'hFFFFFFFF; tb[3] = 32'h1;
    te[3] = {32'h1, 3'b100};
    tc[4] = CMD_SLT;  ta[4] = 32'h7FFFFFFF; tb[4] = 32'h80000000;
    te[4] = {32'h0, 3'b011};
    tc[5] = CMD_AND;  te[5] = {32'hF000F000, 3'b000};
    tc[6] = CMD_OR;   te[6] = {32'hFFF0FFF0, 3'b000};
    tc[7] = CMD_XOR;  te[7] = {32'h0FF00FF0, 3'b000};
    tc[8] = CMD_NAND; te[8] = {32'h0FFF0FFF, 3'b000};
    tc[9] = CMD_NOR;  te[9] = {32'h000F000F, 3'b000};
    for (int i = 5; i < 10; i++) begin
      ta[i] = 32'hF0F0F0F0; tb[i] = 32'hFF00FF00;
    end
    for (int i = 0; i < 10; i++) begin
      run_op(tc[i], ta[i], tb[i], lat);
      n_tests++;
      if (lat !== 8) begin
        n_fail++;
        $display("FAIL dir%0d_latency: got %0d exp 8", i, lat);
      end
      n_tests++;
      if ({result, carryout, overflow, zero} !== te[i]) begin
        n_fail++;
        $display("FAIL dir%0d: got r=%h co=%b ov=%b z=%b exp r=%h co=%b ov=%b z=%b",
                 i, result, carryout, overflow, zero,
                 te[i][34:3], te[i][2], te[i][1], te[i][0]);
      end
      consume();
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [2:0]  c;
    logic [31:0] x, y;
    logic [34:0] e;
    int lat;
    for (int i = 0; i < 60; i++) begin
      c = 3'($urandom_range(0, 7));
      x = pick();
      y = pick();
      e = model(c, x, y);
      run_op(c, x, y, lat);
      n_tests++;
      if (lat !== 8 || {result, carryout, overflow, zero} !== e) begin
        n_fail++;
        $display("FAIL rand%0d cmd=%0d a=%h b=%h: got lat=%0d r=%h co=%b ov=%b z=%b exp lat=8 r=%h co=%b ov=%b z=%b",
                 i, c, x, y, lat, result, carryout, overflow, zero,
                 e[34:3], e[2], e[1], e[0]);
      end
      consume();
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d_release: rdy=%b vld=%b exp rdy=1 vld=0",
                 i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [34:0] e;
    int lat;
    e = model(CMD_ADD, 32'h12345678, 32'h11111111);
    run_op(CMD_ADD, 32'h12345678, 32'h11111111, lat);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_valid = 1'b1; command = CMD_AND;
        a = 32'hFFFFFFFF; b = 32'h0;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {result, carryout, overflow, zero} !== e) begin
        n_fail++;
        $display("FAIL stall%0d: vld=%b rdy=%b r=%h co=%b ov=%b z=%b exp vld=1 rdy=0 r=%h co=%b ov=%b z=%b",
                 i, out_valid, in_ready, result, carryout, overflow, zero,
                 e[34:3], e[2], e[1], e[0]);
      end
    end
    consume();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== e[34:3]) begin
      n_fail++;
      $display("FAIL stall_release: rdy=%b vld=%b r=%h exp rdy=1 vld=0 r=%h",
               in_ready, out_valid, result, e[34:3]);
    end
    run_op(CMD_SUB, 32'd10, 32'd3, lat);
    n_tests++;
    if (result !== 32'd7 || carryout !== 1'b1 || lat !== 8) begin
      n_fail++;
      $display("FAIL after_stall: r=%h co=%b lat=%0d exp r=7 co=1 lat=8",
               result, carryout, lat);
    end
    consume();
  endtask

  task automatic test_abort();
    int lat;
    run_op(CMD_ADD, 32'h7FFFFFFF, 32'h1, lat);
    consume();
    command = CMD_ADD; a = 32'hFFFFFFFF; b = 32'h1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, out_valid, result, carryout, overflow, zero}
        !== {1'b1, 1'b0, 32'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL abort: rdy=%b vld=%b r=%h co=%b ov=%b z=%b exp rdy=1 vld=0 all 0",
               in_ready, out_valid, result, carryout, overflow, zero);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(CMD_ADD, 32'd3, 32'd4, lat);
    n_tests++;
    if (result !== 32'd7 || zero !== 1'b0 || lat !== 8) begin
      n_fail++;
      $display("FAIL post_abort: r=%h z=%b lat=%0d exp r=7 z=0 lat=8",
               result, zero, lat);
    end
    consume();
  endtask

  task automatic test_single_cycle();
    int lat;
    command8 = CMD_ADD; a8 = 8'd3; b8 = 8'd4; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    n_tests++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL single_latency: got %0d exp 1", lat);
    end
    n_tests++;
    if ({result8, carryout8, overflow8, zero8} !== {8'd7, 3'b000}) begin
      n_fail++;
      $display("FAIL single_add: r=%h co=%b ov=%b z=%b exp r=07 co=0 ov=0 z=0",
               result8, carryout8, overflow8, zero8);
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    n_tests++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release: rdy=%b vld=%b exp rdy=1 vld=0",
               in_ready8, out_valid8);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_abort();
    test_single_cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
